accum_cpu_core: RTL
===================

Name: accum_cpu_core

Overview:
- Synthesizable fetch/decode/execute controller for the two-word accumulator ISA.
- Replaces the hand-sequenced loop previously written inline in test benches.
- Drives a single-port synchronous RAM (cs/we/oe style) and owns PC, IR1, IR2, MBR and AC.
- Generalised in address and data width; adds SUB, a HALT/resume handshake, a retire strobe and illegal-opcode reporting.

Parameters:
ADDR_WIDTH, 8, memory address width; PC and operand width.
DATA_WIDTH, 8, memory word and AC width; must be >= ADDR_WIDTH and >= 8.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst_n  input  1  synchronous active-low reset.
start  input  1  level; sampled in IDLE or HALT to begin or resume execution.
mem_addr  output  ADDR_WIDTH  RAM address.
mem_wdata  output  DATA_WIDTH  RAM write data (always AC).
mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after the address phase.
mem_cs  output  1  RAM chip select.
mem_we  output  1  RAM write enable.
mem_oe  output  1  RAM output enable.
halted  output  1  high while in HALT.
retire  output  1  one-cycle pulse in the last cycle of each instruction.
illegal_op  output  1  one-cycle pulse in DEC for an undefined opcode.
pc_out  output  ADDR_WIDTH  current PC.
ac_out  output  DATA_WIDTH  current AC.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; PC, IR1, IR2, MBR and AC clear to 0.
  - All outputs are 0 from the following cycle.
  - Applies in any state and aborts the instruction in flight.
- Memory outputs are Moore, decoded from state. Inactive states drive cs=we=oe=0.
- Instruction format:
  - Word 0: opcode = IR1[DATA_WIDTH-1 -: 4]; cond = next 2 bits.
  - Word 1: operand address = IR2[ADDR_WIDTH-1:0].
- FSM states: IDLE, F0, F0W, F1, F1W, DEC, RD, RDW, EXE, WR, HALT.
  - IDLE: if start, go to F0.
  - F0: addr=PC, cs=1, oe=1.
  - F0W: IR1<=rdata, PC<=PC+1, go to F1.
  - F1: addr=PC, cs=1, oe=1.
  - F1W: IR2<=rdata, PC<=PC+1, go to DEC.
- DEC actions by opcode:
  - 1 LOAD, 3 ADD, 4 SUB: go to RD.
  - 2 STORE: go to WR.
  - 9 JUMP: PC<=IR2; retire; go to F0.
  - A CLEAR: AC<=0; retire; go to F0.
  - 8 SKIPCOND: skip means PC<=PC+2; retire; go to F0.
    - cond 00: skip if AC is signed negative.
    - cond 01: skip if AC==0.
    - cond 10: skip if AC is signed positive and nonzero.
    - cond 11: always skip.
  - 7 HALT: retire; go to HALT.
  - Any other opcode: illegal_op=1, retire, go to F0 (treated as NOP).
- Memory-operand states:
  - RD: addr=IR2, cs=1, oe=1.
  - RDW: MBR<=rdata.
  - EXE: LOAD sets AC<=MBR; ADD sets AC<=AC+MBR; SUB sets AC<=AC-MBR. Retire, go to F0.
  - WR: addr=IR2, cs=1, we=1, oe=0, wdata=AC. Retire, go to F0.
- Arithmetic: AC wraps modulo 2^DATA_WIDTH; no carry or overflow flags.
- PC and addresses wrap modulo 2^ADDR_WIDTH. A fetch at PC = max wraps to 0 for the second word.
- Latency from F0 to retire, inclusive:
  - LOAD/ADD/SUB: 8 cycles.
  - STORE: 6 cycles.
  - JUMP/CLEAR/SKIP/HALT/illegal: 5 cycles.
- HALT state:
  - halted=1; PC is held pointing after the HALT instruction.
  - If start is high, go to F0 (resume).
- start outside IDLE/HALT is ignored.
- Reset timing around STORE:
  - Reset asserted in DEC or earlier: no write occurs.
  - Reset asserted during WR: the RAM still samples the write on that edge.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-fetch -> pc_out=0, ac_out=0, mem_cs=0, halted=0, state IDLE, start ignored until it is seen in IDLE.
- Program load/add/store:
  - Memory: mem[0..7]=10 20 30 21 20 22 70 00, mem[20]=05, mem[21]=07; pulse start.
  - Expect: mem[22]=0C, ac_out=0C, pc_out=08, halted=1.
  - Expect retire pulses at cycles 8, 16, 22 and 27 after F0 entry.
- SUB with signed skip:
  - Setup: AC=03, mem[20]=05; program 40 20 80 00 A0 00 70 00.
  - Expect: AC=FE; the CLEAR is skipped; final ac_out=FE, pc_out=08.
- Jump and wrap:
  - Program 90 FE at 00; mem[FE]=A0, mem[FF]=00.
  - Expect: PC=FE after 5 cycles; after CLEAR, PC wraps to 00 and execution repeats.
- Illegal opcode: word 50 00 -> illegal_op high exactly 1 cycle in DEC, AC unchanged, PC+2.
- HALT resume and STORE abort:
  - HALT with start low for 10 cycles -> outputs stable.
  - Raise start -> next instruction is fetched from PC.
  - Assert rst_n=0 in the DEC cycle of a STORE -> the target word is unchanged.

Source files
------------

// File: rtl/accum_cpu_core_if.sv
// accum_cpu_core_if: single-port synchronous RAM bus (cs/we/oe) between core and memory
interface accum_cpu_core_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  modport master(output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, input mem_rdata);
  modport slave(input mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, output mem_rdata);
endinterface

// File: rtl/accum_cpu_core.sv
// accum_cpu_core: fetch/decode/execute controller for the two-word accumulator ISA
module accum_cpu_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  accum_cpu_core_if.master      mem,
  output logic                  halted,
  output logic                  retire,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out
);
  typedef enum logic [3:0] {IDLE, F0, F0W, F1, F1W, DEC, RD, RDW, EXE, WR, HALT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ir2_q, ir2_d;
  logic [5:0]            ir1_q, ir1_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d, ac_q, ac_d;
  logic [3:0]            opcode;
  logic [1:0]            cond;
  logic                  ac_neg, ac_zero, skip;
  assign opcode  = ir1_q[5:2];
  assign cond    = ir1_q[1:0];
  assign ac_neg  = ac_q[DATA_WIDTH-1];
  assign ac_zero = ac_q == '0;
  assign skip    = cond == 2'd0 ? ac_neg :
                   cond == 2'd1 ? ac_zero :
                   cond == 2'd2 ? !ac_neg && !ac_zero : 1'b1;
  assign mem.mem_wdata = ac_q;
  assign halted = state_q == HALT;
  assign pc_out = pc_q;
  assign ac_out = ac_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir1_d        = ir1_q;
    ir2_d        = ir2_q;
    mbr_d        = mbr_q;
    ac_d         = ac_q;
    retire       = 1'b0;
    illegal_op   = 1'b0;
    mem.mem_addr = pc_q;
    mem.mem_cs   = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_oe   = 1'b0;
    case (state_q)
      IDLE: state_d = start ? F0 : IDLE;
      F0, F1: begin
        mem.mem_cs = 1'b1;
        mem.mem_oe = 1'b1;
        state_d    = state_q == F0 ? F0W : F1W;
      end
      F0W: begin
        ir1_d   = mem.mem_rdata[DATA_WIDTH-1 -: 6];
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = F1;
      end
      F1W: begin
        ir2_d   = mem.mem_rdata[ADDR_WIDTH-1:0];
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = DEC;
      end
      DEC: begin
        state_d = F0;
        retire  = 1'b1;
        case (opcode)
          4'h1, 4'h3, 4'h4: begin
            state_d = RD;
            retire  = 1'b0;
          end
          4'h2: begin
            state_d = WR;
            retire  = 1'b0;
          end
          4'h9: pc_d = ir2_q;
          4'hA: ac_d = '0;
          4'h8: pc_d = skip ? pc_q + ADDR_WIDTH'(2) : pc_q;
          4'h7: state_d = HALT;
          default: illegal_op = 1'b1;
        endcase
      end
      RD: begin
        mem.mem_addr = ir2_q;
        mem.mem_cs   = 1'b1;
        mem.mem_oe   = 1'b1;
        state_d      = RDW;
      end
      RDW: begin
        mbr_d   = mem.mem_rdata;
        state_d = EXE;
      end
      EXE: begin
        ac_d    = opcode == 4'h1 ? mbr_q : opcode == 4'h3 ? ac_q + mbr_q : ac_q - mbr_q;
        retire  = 1'b1;
        state_d = F0;
      end
      WR: begin
        mem.mem_addr = ir2_q;
        mem.mem_cs   = 1'b1;
        mem.mem_we   = 1'b1;
        retire       = 1'b1;
        state_d      = F0;
      end
      HALT: state_d = start ? F0 : HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir1_q   <= '0;
      ir2_q   <= '0;
      mbr_q   <= '0;
      ac_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      mbr_q   <= mbr_d;
      ac_q    <= ac_d;
    end
  end
endmodule
